cpu_ctrl_fsm: RTL and testbench

Multi-cycle control sequencer for the tiny 8-bit CPU. It drives the instruction register load, program counter, accumulator/ALU and memory strobes through fetch, decode and execute phases. It decodes the 4-bit opcode held in the instruction register and handles a ready-handshaked memory with a bus timeout. It sits between the instruction register output and the datapath control inputs.

---
 rtl/cpu_ctrl_fsm.sv | 177 +++++++++++++++++
 tb/tb_cpu_ctrl_fsm.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute sequencer for the tiny 8-bit CPU.
// Drives datapath strobes from the IR opcode; handles ready-handshaked memory with an optional bus timeout.
module cpu_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] inst,
  input  logic       mem_ready,
  input  logic       acc_zero,
  output logic       ir_load,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       mem_rd,
  output logic       mem_wr,
  output logic       addr_sel,
  output logic       acc_load,
  output logic [1:0] alu_op,
  output logic       halted,
  output logic       illegal,
  output logic       bus_err,
  output logic [2:0] state_dbg
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] FETCH  = 3'd1;
  localparam logic [2:0] DECODE = 3'd2;
  localparam logic [2:0] MEM_RD = 3'd3;
  localparam logic [2:0] MEM_WR = 3'd4;
  localparam logic [2:0] HALT   = 3'd5;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_JMP = 4'h5;
  localparam logic [3:0] OP_JZ  = 4'h6;
  localparam logic [3:0] OP_HLT = 4'h7;

  localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);
  localparam logic       TIMEOUT_EN  = (TIMEOUT != 0);

  logic [2:0] state_reg, state_next;
  logic [7:0] wait_reg, wait_next;
  logic       illegal_reg, illegal_next;
  logic       bus_err_reg, bus_err_next;

  logic [3:0] opcode;
  logic       in_access;
  logic       timeout_hit;
  logic       unused_operand;

  assign opcode    = inst[7:4];
  assign in_access = (state_reg == FETCH) || (state_reg == MEM_RD) || (state_reg == MEM_WR);
  // The access that sees mem_ready in the cycle the counter equals TIMEOUT still completes.
  assign timeout_hit = TIMEOUT_EN && in_access && !mem_ready && (wait_reg == TIMEOUT_CNT);

  // Operand bits only feed the datapath (address / jump target).
  assign unused_operand = ^inst[3:0];

  always_comb begin
    state_next   = state_reg;
    illegal_next = illegal_reg;
    bus_err_next = bus_err_reg;
    case (state_reg)
      IDLE: begin
        if (start) state_next = FETCH;
      end
      FETCH: begin
        if (mem_ready) begin
          state_next = DECODE;
        end else if (timeout_hit) begin
          bus_err_next = 1'b1;
          state_next   = HALT;
        end
      end
      DECODE: begin
        case (opcode)
          OP_NOP, OP_JMP, OP_JZ:  state_next = FETCH;
          OP_LDA, OP_ADD, OP_SUB: state_next = MEM_RD;
          OP_STA:                 state_next = MEM_WR;
          OP_HLT:                 state_next = HALT;
          default: begin
            illegal_next = 1'b1;
            state_next   = HALT;
          end
        endcase
      end
      MEM_RD, MEM_WR: begin
        if (mem_ready) begin
          state_next = FETCH;
        end else if (timeout_hit) begin
          bus_err_next = 1'b1;
          state_next   = HALT;
        end
      end
      HALT:    state_next = HALT;
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every state change, so each access entry begins at zero.
  always_comb begin
    wait_next = wait_reg;
    if (state_next != state_reg) begin
      wait_next = 8'd0;
    end else if (in_access && !mem_ready && (wait_reg != 8'hFF)) begin
      wait_next = wait_reg + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= IDLE;
      wait_reg    <= 8'd0;
      illegal_reg <= 1'b0;
      bus_err_reg <= 1'b0;
    end else begin
      state_reg   <= state_next;
      wait_reg    <= wait_next;
      illegal_reg <= illegal_next;
      bus_err_reg <= bus_err_next;
    end
  end

  // Everything is forced low during reset so an in-flight access drops its strobes immediately.
  always_comb begin
    ir_load   = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    addr_sel  = 1'b0;
    acc_load  = 1'b0;
    alu_op    = 2'b00;
    halted    = 1'b0;
    illegal   = 1'b0;
    bus_err   = 1'b0;
    state_dbg = 3'd0;
    if (!rst) begin
      illegal   = illegal_reg;
      bus_err   = bus_err_reg;
      state_dbg = state_reg;
      case (state_reg)
        FETCH: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            ir_load = 1'b1;
            pc_inc  = 1'b1;
          end
        end
        DECODE: begin
          pc_load = (opcode == OP_JMP) || ((opcode == OP_JZ) && acc_zero);
        end
        MEM_RD: begin
          mem_rd   = 1'b1;
          addr_sel = 1'b1;
          acc_load = mem_ready;
          case (opcode)
            OP_ADD:  alu_op = 2'b01;
            OP_SUB:  alu_op = 2'b10;
            default: alu_op = 2'b00;
          endcase
        end
        MEM_WR: begin
          mem_wr   = 1'b1;
          addr_sel = 1'b1;
        end
        HALT:    halted = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_fsm.sv
// Bench for cpu_ctrl_fsm: three instances (TIMEOUT 15, 4, 0) checked every cycle against a spec-level model,
// plus hand-computed expectations for each scenario.
module tb_cpu_ctrl_fsm;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic mem_ready = 1'b0;
  logic acc_zero = 1'b0;
  logic [7:0] inst = 8'h00;

  // {ir_load,pc_inc,pc_load,mem_rd,mem_wr,addr_sel,acc_load,alu_op[1:0],halted,illegal,bus_err,state_dbg[2:0]}
  logic [14:0] obs [3];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    logic       ir_load, pc_inc, pc_load, mem_rd, mem_wr, addr_sel, acc_load;
    logic [1:0] alu_op;
    logic       halted, illegal, bus_err;
    logic [2:0] state_dbg;

    cpu_ctrl_fsm #(.TIMEOUT(gi == 0 ? 15 : (gi == 1 ? 4 : 0))) u_dut (
      .clk(clk), .rst(rst), .start(start), .inst(inst),
      .mem_ready(mem_ready), .acc_zero(acc_zero),
      .ir_load(ir_load), .pc_inc(pc_inc), .pc_load(pc_load),
      .mem_rd(mem_rd), .mem_wr(mem_wr), .addr_sel(addr_sel),
      .acc_load(acc_load), .alu_op(alu_op), .halted(halted),
      .illegal(illegal), .bus_err(bus_err), .state_dbg(state_dbg)
    );

    assign obs[gi] = {ir_load, pc_inc, pc_load, mem_rd, mem_wr, addr_sel,
                      acc_load, alu_op, halted, illegal, bus_err, state_dbg};
  end

  // ---------------- behavioural model ----------------
  // Phases use the published state encodings; m_age = cycles already spent stalled in the current access.
  int m_ph [3]   = '{0, 0, 0};
  int m_age [3]  = '{0, 0, 0};
  bit m_ill [3]  = '{0, 0, 0};
  bit m_berr [3] = '{0, 0, 0};

  function automatic int tmo(input int i);
    return (i == 0) ? 15 : ((i == 1) ? 4 : 0);
  endfunction

  function automatic logic [14:0] expect_out(input int i);
    logic [14:0] e;
    int op;
    e  = '0;
    op = int'(inst[7:4]);
    if (rst) return '0;
    case (m_ph[i])
      1: begin
        e[11] = 1'b1;
        if (mem_ready) begin e[14] = 1'b1; e[13] = 1'b1; end
      end
      2: e[12] = (op == 5) || ((op == 6) && acc_zero);
      3: begin
        e[11]  = 1'b1;
        e[9]   = 1'b1;
        e[8]   = mem_ready;
        e[7:6] = (op == 3) ? 2'b01 : ((op == 4) ? 2'b10 : 2'b00);
      end
      4: begin e[10] = 1'b1; e[9] = 1'b1; end
      5: e[5] = 1'b1;
      default: ;
    endcase
    e[4]   = m_ill[i];
    e[3]   = m_berr[i];
    e[2:0] = 3'(m_ph[i]);
    return e;
  endfunction

  task automatic advance(input int i);
    int op;
    op = int'(inst[7:4]);
    if (rst) begin
      m_ph[i] = 0; m_age[i] = 0; m_ill[i] = 0; m_berr[i] = 0;
      return;
    end
    case (m_ph[i])
      0: if (start) m_ph[i] = 1;
      1, 3, 4: begin
        if (mem_ready) begin
          m_ph[i]  = (m_ph[i] == 1) ? 2 : 1;
          m_age[i] = 0;
        end else if (tmo(i) != 0 && m_age[i] == tmo(i)) begin
          m_berr[i] = 1;
          m_ph[i]   = 5;
          m_age[i]  = 0;
        end else begin
          m_age[i]++;
        end
      end
      2: begin
        case (op)
          0, 5, 6: m_ph[i] = 1;
          1, 3, 4: m_ph[i] = 3;
          2:       m_ph[i] = 4;
          7:       m_ph[i] = 5;
          default: begin m_ill[i] = 1; m_ph[i] = 5; end
        endcase
      end
      default: ;
    endcase
  endtask

  always @(negedge clk) begin
    logic [14:0] e;
    for (int i = 0; i < 3; i++) begin
      e = expect_out(i);
      tests++;
      if (obs[i] !== e) begin
        fails++;
        $display("FAIL cycle_check dut%0d t=%0t got=%h expected=%h", i, $time, obs[i], e);
      end
      advance(i);
    end
  end

  // ---------------- stimulus and memory/IR emulation ----------------
  logic [7:0] prog [$];
  int ip = 0;
  int lat = 0;   // wait states per access; -1 = memory never ready
  int age = 0;
  int trace [$];
  int alu_q [$];
  int n_acc, n_wr, n_pcload, ir_cycle;
  int n_rd [3];
  int n_ir [3];

  int exp_prog [13] = '{0, 1, 2, 3, 1, 2, 3, 1, 2, 4, 1, 2, 5};
  int exp_ill [4]   = '{0, 1, 2, 5};

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    logic ld, strb;
    @(negedge clk);
    ld   = obs[0][14];
    strb = obs[0][11] | obs[0][10];
    trace.push_back(int'(obs[0][2:0]));
    if (obs[0][8])  n_acc++;
    if (obs[0][10]) n_wr++;
    if (obs[0][12]) n_pcload++;
    if (obs[0][2:0] == 3'd3) alu_q.push_back(int'(obs[0][7:6]));
    for (int i = 0; i < 3; i++) begin
      if (obs[i][11]) n_rd[i]++;
      if (obs[i][14]) n_ir[i]++;
    end
    if (ld) ir_cycle = trace.size();
    if (rst || !strb || mem_ready) age = 0;
    else age++;
    @(posedge clk);
    #1;
    if (ld && ip < prog.size()) begin
      inst = prog[ip];
      ip++;
    end
    #1;
    mem_ready = (obs[0][11] | obs[0][10]) && (lat >= 0) && (age >= lat);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start = 1'b0;
    tick();
  endtask

  // Releases reset and pulses start in the very first cycle out of reset.
  task automatic begin_run(input int l);
    lat = l;
    ip = 0;
    inst = 8'h00;
    trace.delete();
    alu_q.delete();
    n_acc = 0; n_wr = 0; n_pcload = 0; ir_cycle = 0;
    for (int i = 0; i < 3; i++) begin n_rd[i] = 0; n_ir[i] = 0; end
    rst = 1'b0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  initial begin
    bit found;
    repeat (3) tick();
    check("reset_outputs_zero", int'(obs[0]), 0);

    // LDA, ADD, STA, HLT with zero-wait memory
    prog = '{8'h13, 8'h34, 8'h22, 8'h70};
    begin_run(0);
    repeat (12) tick();
    check("prog_trace_len", trace.size(), 13);
    for (int k = 0; k < 13 && k < trace.size(); k++)
      check($sformatf("prog_state_%0d", k), trace[k], exp_prog[k]);
    check("prog_rd_phases", alu_q.size(), 2);
    if (alu_q.size() == 2) begin
      check("prog_alu_lda", alu_q[0], 0);
      check("prog_alu_add", alu_q[1], 1);
    end
    check("prog_acc_load_pulses", n_acc, 2);
    check("prog_mem_wr_pulses", n_wr, 1);
    check("prog_halted", int'(obs[0][5]), 1);
    start = 1'b1;
    repeat (3) tick();
    start = 1'b0;
    check("halt_ignores_start", int'(obs[0][2:0]), 5);

    // NOP, JMP, JZ taken, HLT
    do_reset();
    acc_zero = 1'b1;
    prog = '{8'h00, 8'h51, 8'h65, 8'h70};
    begin_run(0);
    repeat (9) tick();
    check("jz_taken_pc_loads", n_pcload, 2);
    check("jz_taken_halt", int'(obs[0][2:0]), 5);

    // Same program, JZ not taken
    do_reset();
    acc_zero = 1'b0;
    begin_run(0);
    repeat (9) tick();
    check("jz_not_taken_pc_loads", n_pcload, 1);
    if (trace.size() == 10) begin
      check("jz_not_taken_next_fetch", trace[7], 1);
      check("jz_not_taken_end", trace[9], 5);
    end else begin
      check("jz_trace_len", trace.size(), 10);
    end

    // Three wait states on fetch
    do_reset();
    prog = '{8'h70};
    begin_run(3);
    repeat (7) tick();
    check("wait_mem_rd_cycles", n_rd[0], 4);
    check("wait_ir_load_pulses", n_ir[0], 1);
    check("wait_ir_load_cycle", ir_cycle, 5);
    check("wait_halt", int'(obs[0][2:0]), 5);

    // Memory never ready
    do_reset();
    prog = '{8'h70};
    begin_run(-1);
    repeat (24) tick();
    check("stuck_t15_mem_rd_cycles", n_rd[0], 16);
    check("stuck_t4_mem_rd_cycles", n_rd[1], 5);
    check("stuck_t0_mem_rd_cycles", n_rd[2], 24);
    check("stuck_t4_bus_err", int'(obs[1][3]), 1);
    check("stuck_t4_state", int'(obs[1][2:0]), 5);
    check("stuck_t15_bus_err", int'(obs[0][3]), 1);
    check("stuck_t0_bus_err", int'(obs[2][3]), 0);
    check("stuck_t0_state", int'(obs[2][2:0]), 1);
    for (int i = 0; i < 3; i++)
      check($sformatf("stuck_ir_load_dut%0d", i), n_ir[i], 0);

    // Ready arrives exactly when the TIMEOUT=4 counter reaches 4
    do_reset();
    prog = '{8'h13, 8'h70};
    begin_run(4);
    repeat (19) tick();
    check("edge_t4_bus_err", int'(obs[1][3]), 0);
    check("edge_t4_halted", int'(obs[1][5]), 1);
    check("edge_t4_ir_loads", n_ir[1], 2);
    check("edge_acc_load", n_acc, 1);

    // One cycle later: TIMEOUT=4 expires, TIMEOUT=15 does not
    do_reset();
    prog = '{8'h70};
    begin_run(5);
    repeat (9) tick();
    check("late_t4_bus_err", int'(obs[1][3]), 1);
    check("late_t4_ir_loads", n_ir[1], 0);
    check("late_t15_bus_err", int'(obs[0][3]), 0);
    check("late_t15_halted", int'(obs[0][5]), 1);

    // Illegal opcode, then reset clears it
    do_reset();
    prog = '{8'h9A};
    begin_run(0);
    repeat (3) tick();
    check("ill_trace_len", trace.size(), 4);
    for (int k = 0; k < 4 && k < trace.size(); k++)
      check($sformatf("ill_state_%0d", k), trace[k], exp_ill[k]);
    check("ill_flag", int'(obs[0][4]), 1);
    rst = 1'b1;
    tick();
    check("ill_outputs_in_reset", int'(obs[0]), 0);
    rst = 1'b0;
    tick();
    check("ill_cleared", int'(obs[0][4]), 0);
    check("ill_state_idle", int'(obs[0][2:0]), 0);

    // Reset during a MEM_WR wait cycle
    do_reset();
    prog = '{8'h22};
    begin_run(3);
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      tick();
      if (obs[0][2:0] == 3'd4) found = 1'b1;
    end
    check("reach_mem_wr", int'(found), 1);
    rst = 1'b1;
    tick();
    check("rst_mem_wr_dropped", n_wr, 0);
    rst = 1'b0;
    tick();
    check("rst_state_idle", int'(obs[0][2:0]), 0);
    check("rst_no_acc_load", n_acc, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
